// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet stream arbiter: FSM states,
// legal last-beat keep encodings and MTU-derived beat limits.
package pkt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [3:0] KEEP_0B = 4'b0000;
  localparam logic [3:0] KEEP_1B = 4'b0001;
  localparam logic [3:0] KEEP_2B = 4'b0011;
  localparam logic [3:0] KEEP_3B = 4'b0111;
  localparam logic [3:0] KEEP_4B = 4'b1111;

  localparam int MTU_BYTES         = 1522;
  localparam int DEFAULT_MAX_BEATS = (MTU_BYTES + 3) / 4;

  // Only contiguous low-aligned byte masks are meaningful to the decoder.
  function automatic logic keep_is_legal(input logic [3:0] k);
    return (k == KEEP_0B) || (k == KEEP_1B) || (k == KEEP_2B) ||
           (k == KEEP_3B) || (k == KEEP_4B);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: returns the first requester found
// scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC.
module rr_picker #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0]   cand_idx  [NUM_SRC];
  logic [NUM_SRC-1:0] cand_req;
  logic [IDX_W-1:0]   idx_chain [NUM_SRC+1];

  assign idx_chain[NUM_SRC] = '0;

  // Candidate gi is offset gi+1 from the pointer; lower offsets win.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum = {1'b0, rr_ptr} + (IDX_W+1)'(gi + 1);
    assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_SRC)) ?
                          IDX_W'(sum - (IDX_W+1)'(NUM_SRC)) : sum[IDX_W-1:0];
    assign cand_req[gi]  = req[cand_idx[gi]];
    assign idx_chain[gi] = cand_req[gi] ? cand_idx[gi] : idx_chain[gi+1];
  end

  assign found = |req;
  assign idx   = idx_chain[0];

endmodule

// File: rtl/packet_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding packet_decoder's single beat
// input, with post-packet idle gap, MTU truncation and keep checking.
module packet_stream_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int MAX_BEATS  = DEFAULT_MAX_BEATS,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC*32-1:0]      src_packet4_byte,
  input  logic [NUM_SRC-1:0]         src_data_valid,
  input  logic [NUM_SRC-1:0]         src_last_valid,
  input  logic [NUM_SRC*4-1:0]       src_keep,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [31:0]                packet4_byte,
  output logic                       data_valid,
  output logic                       last_valid,
  output logic [3:0]                 keep,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           trunc_cnt,
  output logic                       keep_err
);

  localparam int IDX_W  = $clog2(NUM_SRC);
  localparam int BCNT_W = $clog2(MAX_BEATS + 1);
  localparam int GCNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [BCNT_W-1:0] LAST_CNT = BCNT_W'(MAX_BEATS - 1);
  localparam logic [GCNT_W-1:0] GAP_END  = GCNT_W'(GAP_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    grant_reg, grant_next;
  logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [BCNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [GCNT_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [31:0]         data_reg, data_next;
  logic                data_valid_reg, data_valid_next;
  logic                last_valid_reg, last_valid_next;
  logic [3:0]          keep_reg, keep_next;
  logic [CNT_W-1:0]    trunc_cnt_reg, trunc_cnt_next;
  logic                keep_err_reg, keep_err_next;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic [31:0]         beat_arr [NUM_SRC];
  logic [3:0]          keep_arr [NUM_SRC];
  logic                sel_valid, sel_last;
  logic [31:0]         sel_data;
  logic [3:0]          sel_keep;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign beat_arr[gi]  = src_packet4_byte[32*gi +: 32];
    assign keep_arr[gi]  = src_keep[4*gi +: 4];
    assign src_ready[gi] = ((state_reg == FWD) || (state_reg == DROP)) &&
                           (grant_reg == IDX_W'(gi));
  end

  assign sel_valid = src_data_valid[grant_reg];
  assign sel_last  = src_last_valid[grant_reg];
  assign sel_data  = beat_arr[grant_reg];
  assign sel_keep  = keep_arr[grant_reg];

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req    (src_data_valid),
    .rr_ptr (rr_ptr_reg),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    rr_ptr_next     = rr_ptr_reg;
    beat_cnt_next   = beat_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    data_next       = data_reg;
    keep_next       = keep_reg;
    data_valid_next = 1'b0;
    last_valid_next = 1'b0;
    trunc_cnt_next  = trunc_cnt_reg;
    keep_err_next   = keep_err_reg;

    unique case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next    = pick_idx;
          beat_cnt_next = '0;
          state_next    = FWD;
        end
      end
      FWD: begin
        if (sel_valid) begin
          data_valid_next = 1'b1;
          data_next       = sel_data;
          keep_next       = KEEP_4B;
          beat_cnt_next   = beat_cnt_reg + 1'b1;
          if (sel_last) begin
            last_valid_next = 1'b1;
            rr_ptr_next     = grant_reg;
            gap_cnt_next    = '0;
            state_next      = GAP;
            if (keep_is_legal(sel_keep)) keep_next = sel_keep;
            else                         keep_err_next = 1'b1;
          end else if (beat_cnt_reg == LAST_CNT) begin
            // MTU reached: close the packet downstream, swallow the rest.
            last_valid_next = 1'b1;
            rr_ptr_next     = grant_reg;
            state_next      = DROP;
            if (trunc_cnt_reg != '1) trunc_cnt_next = trunc_cnt_reg + 1'b1;
          end
        end
      end
      DROP: begin
        if (sel_valid && sel_last) begin
          gap_cnt_next = '0;
          state_next   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_END) state_next   = IDLE;
        else                        gap_cnt_next = gap_cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= IDX_W'(NUM_SRC - 1);
      beat_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      last_valid_reg <= 1'b0;
      keep_reg       <= '0;
      trunc_cnt_reg  <= '0;
      keep_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      rr_ptr_reg     <= rr_ptr_next;
      beat_cnt_reg   <= beat_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      last_valid_reg <= last_valid_next;
      keep_reg       <= keep_next;
      trunc_cnt_reg  <= trunc_cnt_next;
      keep_err_reg   <= keep_err_next;
    end
  end

  assign packet4_byte = data_reg;
  assign data_valid   = data_valid_reg;
  assign last_valid   = last_valid_reg;
  assign keep         = keep_reg;
  assign grant_id     = grant_reg;
  assign busy         = (state_reg != IDLE);
  assign trunc_cnt    = trunc_cnt_reg;
  assign keep_err     = keep_err_reg;

endmodule

// File: tb/tb_packet_stream_arbiter.sv
// Randomized bench for packet_stream_arbiter: per-source packet queues drive the
// DUT, a packet-level round-robin model predicts the forwarded beat stream.
module tb_packet_stream_arbiter;

  localparam int NUM_SRC    = 4;
  localparam int MAX_BEATS  = 381;
  localparam int GAP_CYCLES = 1;
  localparam int CNT_W      = 16;
  localparam int IDX_W      = $clog2(NUM_SRC);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_SRC*32-1:0] src_packet4_byte;
  logic [NUM_SRC-1:0]    src_data_valid;
  logic [NUM_SRC-1:0]    src_last_valid;
  logic [NUM_SRC*4-1:0]  src_keep;
  logic [NUM_SRC-1:0]    src_ready;
  logic [31:0]           packet4_byte;
  logic                  data_valid;
  logic                  last_valid;
  logic [3:0]            keep;
  logic [IDX_W-1:0]      grant_id;
  logic                  busy;
  logic [CNT_W-1:0]      trunc_cnt;
  logic                  keep_err;

  logic        sv [NUM_SRC];
  logic        sl [NUM_SRC];
  logic [31:0] sd [NUM_SRC];
  logic [3:0]  sk [NUM_SRC];
  logic        rdy [NUM_SRC];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_map
    assign src_data_valid[gi]           = sv[gi];
    assign src_last_valid[gi]           = sl[gi];
    assign src_packet4_byte[32*gi +: 32] = sd[gi];
    assign src_keep[4*gi +: 4]          = sk[gi];
    assign rdy[gi]                      = src_ready[gi];
  end

  packet_stream_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .MAX_BEATS  (MAX_BEATS),
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .src_packet4_byte (src_packet4_byte),
    .src_data_valid   (src_data_valid),
    .src_last_valid   (src_last_valid),
    .src_keep         (src_keep),
    .src_ready        (src_ready),
    .packet4_byte     (packet4_byte),
    .data_valid       (data_valid),
    .last_valid       (last_valid),
    .keep             (keep),
    .grant_id         (grant_id),
    .busy             (busy),
    .trunc_cnt        (trunc_cnt),
    .keep_err         (keep_err)
  );

  typedef struct {
    int          len;
    logic [3:0]  keep;
    logic [31:0] salt;
    int          stall_at;
    int          stall_len;
  } pkt_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
  } beat_t;

  pkt_t  src_q [NUM_SRC][$];
  beat_t exp_q[$];
  int    exp_src[$];
  int    got_gnt[$];
  int    intra_q[$];
  int    exp_trunc;
  logic  exp_kerr;
  int    first_req, first_dv, acc_total;
  int    n_cmp = 0;
  int    n_err = 0;
  logic [3:0] legal_keeps [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};

  function automatic bit keep_ok(input logic [3:0] k);
    return (k == 4'b0000) || (k == 4'b0001) || (k == 4'b0011) ||
           (k == 4'b0111) || (k == 4'b1111);
  endfunction

  function automatic pkt_t mk_pkt(input int len, input logic [3:0] k);
    pkt_t p;
    p.len = len; p.keep = k; p.salt = $urandom; p.stall_at = 0; p.stall_len = 0;
    return p;
  endfunction

  // Packet-level model: each packet boundary grants the next pending source after
  // the previously served one; oversize packets are cut to MAX_BEATS.
  task automatic build_model(input int start_last);
    pkt_t q [NUM_SRC][$];
    pkt_t p;
    int   last_src, s, n;
    bit   found;
    beat_t b;
    for (int i = 0; i < NUM_SRC; i++) q[i] = src_q[i];
    exp_q.delete(); exp_src.delete();
    exp_trunc = 0; exp_kerr = 1'b0;
    last_src = start_last;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      s = 0;
      for (int k = NUM_SRC; k >= 1; k--)
        if (q[(last_src + k) % NUM_SRC].size() > 0) begin
          found = 1'b1; s = (last_src + k) % NUM_SRC;
        end
      if (found) begin
        p = q[s].pop_front();
        n = (p.len > MAX_BEATS) ? MAX_BEATS : p.len;
        for (int bi = 0; bi < n; bi++) begin
          b.data = p.salt + 32'(bi);
          b.last = (bi == n - 1);
          b.keep = 4'b1111;
          if (b.last && p.len <= MAX_BEATS && keep_ok(p.keep)) b.keep = p.keep;
          exp_q.push_back(b);
        end
        if (p.len > MAX_BEATS) exp_trunc++;
        else if (!keep_ok(p.keep)) exp_kerr = 1'b1;
        exp_src.push_back(s);
        last_src = s;
      end
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NUM_SRC; i++) begin
      sv[i] = 1'b0; sl[i] = 1'b0; sd[i] = '0; sk[i] = '0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_srcs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives queued packets, scores every forwarded beat and the inter-packet gap.
  task automatic run_traffic(input bit rand_stall, input int max_cyc);
    int    bidx [NUM_SRC];
    int    scnt [NUM_SRC];
    bit    acc  [NUM_SRC];
    int    cyc, drain, gap_idle, intra, pkt_beats;
    bit    in_pkt, seen_last, all_empty, stall, done;
    pkt_t  p;
    beat_t b, e;
    cyc = 0; drain = 0; gap_idle = 0; intra = 0; pkt_beats = 0;
    in_pkt = 1'b0; seen_last = 1'b0; done = 1'b0;
    got_gnt.delete(); intra_q.delete();
    first_req = -1; first_dv = -1; acc_total = 0;
    for (int i = 0; i < NUM_SRC; i++) begin bidx[i] = 0; scnt[i] = 0; acc[i] = 1'b0; end
    @(posedge clk); #1;
    while (!done) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (acc[i]) begin
          acc_total++;
          bidx[i]++;
          scnt[i] = 0;
          if (bidx[i] >= src_q[i][0].len) begin
            void'(src_q[i].pop_front());
            bidx[i] = 0;
          end
        end
        if (src_q[i].size() == 0) begin
          sv[i] = 1'b0; sl[i] = 1'b0;
        end else begin
          p = src_q[i][0];
          stall = 1'b0;
          if (bidx[i] > 0 && bidx[i] == p.stall_at && scnt[i] < p.stall_len) begin
            stall = 1'b1; scnt[i]++;
          end else if (rand_stall && bidx[i] > 0 && $urandom_range(0, 3) == 0) begin
            stall = 1'b1;
          end
          sv[i] = !stall;
          sd[i] = p.salt + 32'(bidx[i]);
          sl[i] = (bidx[i] == p.len - 1);
          sk[i] = sl[i] ? p.keep : p.salt[7:4];
        end
      end

      @(negedge clk);
      cyc++;
      if (|src_data_valid && first_req < 0) first_req = cyc;
      for (int i = 0; i < NUM_SRC; i++) acc[i] = sv[i] && rdy[i];
      n_cmp++;
      if (!$onehot0(src_ready)) begin
        n_err++;
        $display("FAIL ready_onehot: src_ready=%b is not one-hot-or-zero", src_ready);
      end
      if (data_valid) begin
        if (first_dv < 0) first_dv = cyc;
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_during_data: busy=%b required 1", busy);
        end
        if (!in_pkt) begin
          if (seen_last) begin
            n_cmp++;
            if (gap_idle < GAP_CYCLES + 1) begin
              n_err++;
              $display("FAIL idle_gap: %0d idle cycles, required >= %0d", gap_idle, GAP_CYCLES + 1);
            end
          end
          in_pkt = 1'b1; intra = 0; pkt_beats = 0;
        end
        pkt_beats++;
        b.data = packet4_byte; b.last = last_valid; b.keep = keep;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: unexpected beat data=%h last=%b keep=%b, none required", b.data, b.last, b.keep);
        end else begin
          e = exp_q.pop_front();
          if (b !== e) begin
            n_err++;
            $display("FAIL beat: got data=%h last=%b keep=%b, required data=%h last=%b keep=%b",
                     b.data, b.last, b.keep, e.data, e.last, e.keep);
          end
        end
        if (last_valid) begin
          in_pkt = 1'b0; seen_last = 1'b1; gap_idle = 0;
          intra_q.push_back(intra);
          got_gnt.push_back(int'(grant_id));
          $display("pkt src=%0d beats=%0d keep=%b", grant_id, pkt_beats, keep);
        end
      end else if (in_pkt) begin
        intra++;
      end else begin
        gap_idle++;
      end

      all_empty = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) if (src_q[i].size() != 0) all_empty = 1'b0;
      if (all_empty && exp_q.size() == 0) begin
        drain++;
        if (drain > 4) done = 1'b1;
      end
      if (!done && cyc >= max_cyc) begin
        n_cmp++; n_err++;
        $display("FAIL timeout: %0d cycles, %0d beats still required", cyc, exp_q.size());
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    clear_srcs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin sv[i] = 1'b1; sd[i] = $urandom; sl[i] = 1'b1; sk[i] = 4'hF; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (data_valid !== 1'b0)  begin n_err++; $display("FAIL reset_data_valid: got %b required 0", data_valid); end
    n_cmp++; if (last_valid !== 1'b0)  begin n_err++; $display("FAIL reset_last_valid: got %b required 0", last_valid); end
    n_cmp++; if (packet4_byte !== '0)  begin n_err++; $display("FAIL reset_data: got %h required 0", packet4_byte); end
    n_cmp++; if (keep !== '0)          begin n_err++; $display("FAIL reset_keep: got %b required 0", keep); end
    n_cmp++; if (grant_id !== '0)      begin n_err++; $display("FAIL reset_grant: got %0d required 0", grant_id); end
    n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (trunc_cnt !== '0)     begin n_err++; $display("FAIL reset_trunc: got %0d required 0", trunc_cnt); end
    n_cmp++; if (keep_err !== 1'b0)    begin n_err++; $display("FAIL reset_keep_err: got %b required 0", keep_err); end
    n_cmp++; if (src_ready !== '0)     begin n_err++; $display("FAIL reset_ready: got %b required 0", src_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_srcs();
  endtask

  task automatic test_single();
    apply_reset();
    src_q[0].push_back(mk_pkt(3, 4'b0011));
    build_model(NUM_SRC - 1);
    run_traffic(1'b0, 200);
    n_cmp++;
    if (first_dv - first_req !== 2) begin
      n_err++; $display("FAIL single_latency: got %0d cycles required 2", first_dv - first_req);
    end
    n_cmp++; if (grant_id !== '0) begin n_err++; $display("FAIL single_grant: got %0d required 0", grant_id); end
    n_cmp++; if (trunc_cnt !== '0) begin n_err++; $display("FAIL single_trunc: got %0d required 0", trunc_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < NUM_SRC; i++) src_q[i].push_back(mk_pkt(2, 4'b1111));
    src_q[0].push_back(mk_pkt(2, 4'b0111));
    build_model(NUM_SRC - 1);
    run_traffic(1'b0, 400);
    n_cmp++;
    if (got_gnt.size() !== exp_src.size()) begin
      n_err++; $display("FAIL rr_count: got %0d packets required %0d", got_gnt.size(), exp_src.size());
    end
    for (int i = 0; i < got_gnt.size() && i < exp_src.size(); i++) begin
      n_cmp++;
      if (got_gnt[i] !== exp_src[i]) begin
        n_err++; $display("FAIL rr_order[%0d]: got src %0d required %0d", i, got_gnt[i], exp_src[i]);
      end
    end
  endtask

  task automatic test_truncation();
    apply_reset();
    src_q[1].push_back(mk_pkt(400, 4'b0111));
    src_q[2].push_back(mk_pkt(MAX_BEATS, 4'b0001));
    src_q[3].push_back(mk_pkt(MAX_BEATS + 1, 4'b0011));
    build_model(NUM_SRC - 1);
    run_traffic(1'b0, 3000);
    n_cmp++; if (trunc_cnt !== CNT_W'(2)) begin n_err++; $display("FAIL trunc_cnt: got %0d required 2", trunc_cnt); end
    n_cmp++; if (acc_total !== 400 + MAX_BEATS + MAX_BEATS + 1) begin
      n_err++; $display("FAIL trunc_accepted: got %0d beats required %0d", acc_total, 400 + 2 * MAX_BEATS + 1);
    end
    n_cmp++; if (keep_err !== 1'b0) begin n_err++; $display("FAIL trunc_keep_err: got %b required 0", keep_err); end
  endtask

  task automatic test_keep_err();
    apply_reset();
    src_q[2].push_back(mk_pkt(2, 4'b0101));
    src_q[3].push_back(mk_pkt(1, 4'b0001));
    build_model(NUM_SRC - 1);
    run_traffic(1'b0, 200);
    n_cmp++; if (keep_err !== 1'b1) begin n_err++; $display("FAIL keep_err_sticky: got %b required 1", keep_err); end
    apply_reset();
    @(negedge clk);
    n_cmp++; if (keep_err !== 1'b0) begin n_err++; $display("FAIL keep_err_clear: got %b required 0", keep_err); end
  endtask

  task automatic test_stall();
    pkt_t p;
    apply_reset();
    p = mk_pkt(6, 4'b1111);
    p.stall_at = 3; p.stall_len = 5;
    src_q[0].push_back(p);
    src_q[1].push_back(mk_pkt(2, 4'b0011));
    build_model(NUM_SRC - 1);
    run_traffic(1'b0, 300);
    n_cmp++;
    if (intra_q.size() < 1 || intra_q[0] !== 5) begin
      n_err++; $display("FAIL stall_idle: got %0d idle cycles required 5", (intra_q.size() > 0) ? intra_q[0] : -1);
    end
    n_cmp++;
    if (got_gnt.size() != 2 || got_gnt[0] !== 0 || got_gnt[1] !== 1) begin
      n_err++; $display("FAIL stall_order: got %0d packets, first src %0d, required src0 then src1",
                        got_gnt.size(), (got_gnt.size() > 0) ? got_gnt[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    int cnt, k;
    apply_reset();
    sv[0] = 1'b1; sl[0] = 1'b0; sd[0] = $urandom; sk[0] = 4'hF;
    cnt = 0; k = 0;
    while (cnt < 2 && k < 20) begin
      @(negedge clk);
      if (data_valid) cnt++;
      k++;
    end
    n_cmp++; if (cnt < 2) begin n_err++; $display("FAIL midrst_beats: got %0d beats required 2", cnt); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_srcs();
    @(negedge clk);
    n_cmp++;
    if ({data_valid, last_valid, busy, keep, grant_id} !== '0 || packet4_byte !== '0 || src_ready !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: dv=%b lv=%b busy=%b keep=%b grant=%0d data=%h ready=%b required all 0",
               data_valid, last_valid, busy, keep, grant_id, packet4_byte, src_ready);
    end
    src_q[1].push_back(mk_pkt(2, 4'b1111));
    src_q[0].push_back(mk_pkt(2, 4'b1111));
    build_model(NUM_SRC - 1);
    run_traffic(1'b0, 200);
    n_cmp++;
    if (got_gnt.size() < 1 || got_gnt[0] !== 0) begin
      n_err++; $display("FAIL midrst_first_grant: got src %0d required 0", (got_gnt.size() > 0) ? got_gnt[0] : -1);
    end
  endtask

  task automatic test_random(input int rounds);
    int n, len;
    logic [3:0] k;
    for (int r = 0; r < rounds; r++) begin
      apply_reset();
      for (int i = 0; i < NUM_SRC; i++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) begin
          len = ($urandom_range(0, 11) == 0) ? $urandom_range(MAX_BEATS - 1, MAX_BEATS + 6)
                                              : $urandom_range(1, 8);
          k = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_keeps[$urandom_range(0, 4)];
          src_q[i].push_back(mk_pkt(len, k));
        end
      end
      build_model(NUM_SRC - 1);
      run_traffic(1'b1, 20000);
      n_cmp++;
      if (trunc_cnt !== CNT_W'(exp_trunc)) begin
        n_err++; $display("FAIL rand_trunc: got %0d required %0d", trunc_cnt, exp_trunc);
      end
      n_cmp++;
      if (keep_err !== exp_kerr) begin
        n_err++; $display("FAIL rand_keep_err: got %b required %b", keep_err, exp_kerr);
      end
    end
  endtask

  initial begin
    clear_srcs();
    test_reset();
    test_single();
    test_round_robin();
    test_truncation();
    test_keep_err();
    test_stall();
    test_reset_mid();
    test_random(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
